// File: rtl/audio_clk_pkg.sv
// Shared types for the audio serial-clock generator: framing modes, FSM
// state encoding and the runtime configuration record.
package audio_clk_pkg;

  localparam logic MODE_I2S = 1'b0;
  localparam logic MODE_TDM = 1'b1;

  // Widest half-period divide value the config record can hold; DIV_WIDTH
  // on the top level must not exceed this.
  localparam int CFG_DIV_MAX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  typedef struct packed {
    logic [CFG_DIV_MAX_W-1:0] half_div;
    logic                     mode;
  } cfg_t;

endpackage

// File: rtl/clk_half_divider.sv
// Half-period counter for BCLK: counts 0..i_half_div while running and
// raises o_tc on the terminal count, restarting from 0 on the next cycle.
module clk_half_divider #(
  parameter int W = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_run,
  input  logic [W-1:0] i_half_div,
  output logic         o_tc
);

  logic [W-1:0] cnt;

  // >= rather than == so a count already past a shrunken divide value
  // still terminates instead of wrapping through the whole range.
  assign o_tc = i_run && (cnt >= i_half_div);

  always_ff @(posedge i_clock) begin
    if (i_reset || !i_run || o_tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/audio_clock_divider.sv
// I2S/TDM BCLK and frame-sync generator with aligned bit/frame strobes.
// Divide ratio and mode reload, and stop, only take effect at frame boundaries.
module audio_clock_divider
  import audio_clk_pkg::*;
#(
  parameter int DIV_WIDTH  = 8,
  parameter int SLOT_BITS  = 32,
  parameter int NUM_SLOTS  = 2,
  parameter int SLOT_IDX_W = $clog2(NUM_SLOTS),
  parameter int BIT_IDX_W  = $clog2(SLOT_BITS)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [DIV_WIDTH-1:0]  i_half_div,
  input  logic                  i_mode,
  input  logic                  i_cfg_load,
  output logic                  o_bclk,
  output logic                  o_lrclk,
  output logic                  o_bclk_rise,
  output logic                  o_bclk_fall,
  output logic                  o_frame_start,
  output logic [SLOT_IDX_W-1:0] o_slot,
  output logic [BIT_IDX_W-1:0]  o_bit,
  output logic                  o_busy,
  output state_e                o_state
);

  localparam logic [BIT_IDX_W-1:0]  BIT_LAST  = BIT_IDX_W'(SLOT_BITS - 1);
  localparam logic [SLOT_IDX_W-1:0] SLOT_LAST = SLOT_IDX_W'(NUM_SLOTS - 1);
  localparam logic [SLOT_IDX_W-1:0] SLOT_HALF = SLOT_IDX_W'(NUM_SLOTS / 2);

  state_e state_q, state_d;
  cfg_t   active_q, active_d, pending_q, pending_d, load_cfg;
  logic   pend_q, pend_d;

  logic                  bclk_q, lrclk_q, rise_q, fall_q, fs_q, busy_q;
  logic                  bclk_d, lrclk_d, rise_d, fall_d, fs_d, busy_d;
  logic [SLOT_IDX_W-1:0] slot_q, slot_d;
  logic [BIT_IDX_W-1:0]  bit_q, bit_d;

  logic tc, fall_edge, bit_wrap, frame_wrap, boundary, start;

  clk_half_divider #(.W(CFG_DIV_MAX_W)) u_half_div (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_run      (state_q != ST_IDLE),
    .i_half_div (active_q.half_div),
    .o_tc       (tc)
  );

  assign load_cfg.half_div = CFG_DIV_MAX_W'(i_half_div);
  assign load_cfg.mode     = i_mode;

  assign fall_edge  = tc && bclk_q;
  assign bit_wrap   = (bit_q == BIT_LAST);
  assign frame_wrap = bit_wrap && (slot_q == SLOT_LAST);
  assign boundary   = fall_edge && frame_wrap;
  assign start      = (state_q == ST_IDLE) && i_enable;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (i_enable) state_d = ST_RUN;
      ST_RUN:      if (!i_enable) state_d = ST_STOPPING;
      ST_STOPPING: begin
        if (boundary)      state_d = ST_IDLE;
        else if (i_enable) state_d = ST_RUN;
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  // A load arriving on a boundary cycle lands in pending after the copy,
  // so the boundary consumes the older value.
  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    if (pend_q && (start || (boundary && state_q == ST_RUN))) begin
      active_d = pending_q;
      pend_d   = 1'b0;
    end
    if (i_cfg_load) begin
      if (state_q == ST_IDLE) begin
        active_d = load_cfg;
        pend_d   = 1'b0;
      end else begin
        pending_d = load_cfg;
        pend_d    = 1'b1;
      end
    end
  end

  always_comb begin
    bclk_d  = bclk_q;
    lrclk_d = lrclk_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    fs_d    = 1'b0;
    slot_d  = slot_q;
    bit_d   = bit_q;
    busy_d  = (state_d != ST_IDLE);
    if (state_q == ST_IDLE) begin
      bclk_d  = 1'b0;
      lrclk_d = 1'b0;
      slot_d  = '0;
      bit_d   = '0;
      if (i_enable) begin
        fs_d    = 1'b1;
        lrclk_d = (active_d.mode == MODE_TDM);
      end
    end else if (tc) begin
      bclk_d = !bclk_q;
      rise_d = !bclk_q;
      fall_d = bclk_q;
      if (bclk_q) begin
        bit_d  = bit_wrap ? '0 : bit_q + 1'b1;
        slot_d = !bit_wrap ? slot_q : (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        if (frame_wrap && state_q == ST_STOPPING) begin
          lrclk_d = 1'b0;
        end else begin
          fs_d = frame_wrap;
          if (active_d.mode == MODE_TDM) begin
            lrclk_d = (slot_d == '0) && (bit_d == '0);
          end else begin
            lrclk_d = (slot_d >= SLOT_HALF);
          end
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      active_q  <= '0;
      pending_q <= '0;
      pend_q    <= 1'b0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      fs_q      <= 1'b0;
      busy_q    <= 1'b0;
      slot_q    <= '0;
      bit_q     <= '0;
    end else begin
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      fs_q      <= fs_d;
      busy_q    <= busy_d;
      slot_q    <= slot_d;
      bit_q     <= bit_d;
    end
  end

  assign o_bclk        = bclk_q;
  assign o_lrclk       = lrclk_q;
  assign o_bclk_rise   = rise_q;
  assign o_bclk_fall   = fall_q;
  assign o_frame_start = fs_q;
  assign o_slot        = slot_q;
  assign o_bit         = bit_q;
  assign o_busy        = busy_q;
  assign o_state       = state_q;

endmodule
